dec_pipe_n: RTL and testbench

//  Parametrised, registered N-to-M line decoder with valid/ready flow control.
//  - Successor to the team's fixed 3-to-8 active-low decoder.
//  - Adds generic width, output polarity, bit ordering, out-of-range detection and a
//    2-entry skid buffer, so it drops into streaming select paths at full throughput.

---
 rtl/dec_pipe_pkg.sv | 56 +++++
 rtl/dec_pipe_n_core.sv | 35 +++
 rtl/dec_pipe_n.sv | 180 ++++++++++++++++++
 tb/tb_dec_pipe_n.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dec_pipe_pkg
//   Shared types and the reference decode function for the dec_pipe_n
//   streaming line decoder.
//
//   Contents:
//     state_t       flow-control state of the two-entry output buffer
//     dec_res_t     decode result: err flag plus lines, sized for the widest
//                   supported decoder (DEC_MAX_OUT lines)
//     decode_lines  code -> {err, lines} for a given line count, polarity and
//                   bit ordering
//
//   Supported range: IN_W up to DEC_MAX_IN_W, so NUM_OUT up to DEC_MAX_OUT.
// -----------------------------------------------------------------------------
package dec_pipe_pkg;

    localparam int unsigned DEC_MAX_IN_W = 8;
    localparam int unsigned DEC_MAX_OUT  = 2 ** DEC_MAX_IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic                   err;
        logic [DEC_MAX_OUT-1:0] lines;
    } dec_res_t;

    // Lines above num_out carry no meaning; callers keep only the low
    // num_out bits.  An out-of-range code leaves every line inactive.
    function automatic dec_res_t decode_lines(
        input int unsigned code,
        input int unsigned num_out,
        input bit          active_low,
        input bit          reverse
    );
        dec_res_t                r;
        logic [DEC_MAX_IN_W-1:0] idx;
        r.lines = '0;
        r.err   = 1'b0;
        idx     = '0;
        if (code < num_out) begin
            idx          = DEC_MAX_IN_W'(reverse ? (num_out - 1 - code) : code);
            r.lines[idx] = 1'b1;
        end else begin
            r.err = 1'b1;
        end
        if (active_low) begin
            r.lines = ~r.lines;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_pipe_n_core.sv
// -----------------------------------------------------------------------------
// dec_core
//   Purely combinational code -> {lines, err} decoder.  A single instance in
//   dec_pipe_n feeds both the output register and the skid register.
//
//   Parameters: IN_W, NUM_OUT (2..2**IN_W), ACTIVE_LOW, REVERSE
//
//   Ports:
//     i_code   in   IN_W     code to decode
//     o_lines  out  NUM_OUT  decoded lines (one active, or none if out of range)
//     o_err    out  1        code >= NUM_OUT
// -----------------------------------------------------------------------------
module dec_core
    import dec_pipe_pkg::*;
#(
    parameter int unsigned IN_W       = 3,
    parameter int unsigned NUM_OUT    = 2 ** IN_W,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          REVERSE    = 1'b1
) (
    input  logic [IN_W-1:0]    i_code,
    output logic [NUM_OUT-1:0] o_lines,
    output logic               o_err
);

    // Narrow the package's maximum-width result to this decoder's line count.
    function automatic logic [NUM_OUT:0] decode_fit(input logic [IN_W-1:0] code);
        dec_res_t r;
        r = decode_lines(32'(code), NUM_OUT, ACTIVE_LOW, REVERSE);
        return {r.err, r.lines[NUM_OUT-1:0]};
    endfunction

    assign {o_err, o_lines} = decode_fit(i_code);

endmodule

// File: rtl/dec_pipe_n.sv
// -----------------------------------------------------------------------------
// dec_pipe_n
//   Registered N-to-M line decoder with valid/ready flow control and a
//   two-entry (output + skid) buffer, sustaining one beat per cycle while the
//   consumer is ready.  Latency is one cycle from input to output transfer.
//
//   Parameters:
//     IN_W        width of the input code
//     NUM_OUT     number of output lines, 2..2**IN_W
//     ACTIVE_LOW  1: selected line low, others high; 0: one-hot high
//     REVERSE     1: code c selects bit NUM_OUT-1-c; 0: code c selects bit c
//
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     in_code    in   IN_W     code to decode
//     in_valid   in   1        in_code is valid
//     in_ready   out  1        block can accept a code (registered, state only)
//     out_lines  out  NUM_OUT  decoded lines, all inactive while out_valid=0
//     out_err    out  1        current beat came from a code >= NUM_OUT
//     out_valid  out  1        out_lines/out_err carry a beat
//     out_ready  in   1        downstream accepts the beat
//
//   Optional build macro DEC_PIPE_STATS_EN adds:
//     stat_clr    in   1   synchronous clear of both counters (wins over a beat)
//     stat_beats  out  16  saturating count of output transfers
//     stat_errs   out  16  saturating count of output transfers with out_err=1
// -----------------------------------------------------------------------------
module dec_pipe_n
    import dec_pipe_pkg::*;
#(
    parameter int unsigned IN_W       = 3,
    parameter int unsigned NUM_OUT    = 2 ** IN_W,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          REVERSE    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    in_code,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_lines,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
`ifdef DEC_PIPE_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        stat_beats,
    output logic [15:0]        stat_errs
`endif
);

    localparam logic [NUM_OUT-1:0] LINES_IDLE =
        ACTIVE_LOW ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [NUM_OUT-1:0]   r_out_lines;
    logic                 r_out_err;
    logic [NUM_OUT-1:0]   r_skid_lines;
    logic                 r_skid_err;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic [NUM_OUT-1:0]   w_dec_lines;
    logic                 w_dec_err;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    dec_core #(
        .IN_W       (IN_W),
        .NUM_OUT    (NUM_OUT),
        .ACTIVE_LOW (ACTIVE_LOW),
        .REVERSE    (REVERSE)
    ) u_core (
        .i_code  (in_code),
        .o_lines (w_dec_lines),
        .o_err   (w_dec_err)
    );

    // Stage boundary: input code -> output register / skid register.
    // in_ready and out_valid are registered alongside the state so that no
    // combinational path runs from out_ready to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_lines  <= LINES_IDLE;
            r_out_err    <= 1'b0;
            r_skid_lines <= LINES_IDLE;
            r_skid_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_out_lines <= w_dec_lines;
                        r_out_err   <= w_dec_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_out_lines <= w_dec_lines;
                        r_out_err   <= w_dec_err;
                    end else if (w_in_xfer) begin
                        // Consumer stalled: park the new beat, stop accepting.
                        r_skid_lines <= w_dec_lines;
                        r_skid_err   <= w_dec_err;
                        r_in_ready   <= 1'b0;
                        r_state      <= ST_TWO;
                    end else if (w_out_xfer) begin
                        // Blank the lines so no stale beat is visible while empty.
                        r_out_lines <= LINES_IDLE;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_out_lines  <= r_skid_lines;
                        r_out_err    <= r_skid_err;
                        r_skid_lines <= LINES_IDLE;
                        r_skid_err   <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_state      <= ST_ONE;
                    end
                end
                default: begin
                    r_state      <= ST_EMPTY;
                    r_in_ready   <= 1'b1;
                    r_out_valid  <= 1'b0;
                    r_out_lines  <= LINES_IDLE;
                    r_out_err    <= 1'b0;
                    r_skid_lines <= LINES_IDLE;
                    r_skid_err   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_lines = r_out_lines;
    assign out_err   = r_out_err;

`ifdef DEC_PIPE_STATS_EN
    logic [15:0] r_stat_beats;
    logic [15:0] r_stat_errs;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Stage boundary: output transfer -> statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_beats <= '0;
            r_stat_errs  <= '0;
        end else if (stat_clr) begin
            r_stat_beats <= '0;
            r_stat_errs  <= '0;
        end else if (w_out_xfer) begin
            r_stat_beats <= sat_inc16(r_stat_beats);
            if (r_out_err) begin
                r_stat_errs <= sat_inc16(r_stat_errs);
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_errs  = r_stat_errs;
`endif

endmodule

// File: tb/tb_dec_pipe_n.sv
// -----------------------------------------------------------------------------
// tb_dec_pipe_n
//   Bench for dec_pipe_n.  u0 uses the default configuration and is tracked
//   every cycle by a queue-based model; u1 (REVERSE=0, ACTIVE_LOW=0) and
//   u2 (NUM_OUT=5) get directed checks.  Honours DEC_PIPE_STATS_EN.
// -----------------------------------------------------------------------------
module tb_dec_pipe_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u0: default configuration
    logic [2:0] in_code0;
    logic       in_valid0, out_ready0;
    logic       in_ready0, out_err0, out_valid0;
    logic [7:0] out_lines0;

    // u1 / u2 share their input side
    logic [2:0] in_code1;
    logic       in_valid1, out_ready1;
    logic       in_ready1, out_err1, out_valid1;
    logic [7:0] out_lines1;
    logic       in_ready2, out_err2, out_valid2;
    logic [4:0] out_lines2;

`ifdef DEC_PIPE_STATS_EN
    logic        stat_clr;
    logic [15:0] sb0, se0, sb1, se1, sb2, se2;
`endif

    dec_pipe_n u0 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_lines(out_lines0), .out_err(out_err0),
        .out_valid(out_valid0), .out_ready(out_ready0)
`ifdef DEC_PIPE_STATS_EN
        , .stat_clr(stat_clr), .stat_beats(sb0), .stat_errs(se0)
`endif
    );

    dec_pipe_n #(.IN_W(3), .NUM_OUT(8), .ACTIVE_LOW(1'b0), .REVERSE(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_lines(out_lines1), .out_err(out_err1),
        .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef DEC_PIPE_STATS_EN
        , .stat_clr(stat_clr), .stat_beats(sb1), .stat_errs(se1)
`endif
    );

    dec_pipe_n #(.IN_W(3), .NUM_OUT(5)) u2 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code1), .in_valid(in_valid1),
        .in_ready(in_ready2), .out_lines(out_lines2), .out_err(out_err2),
        .out_valid(out_valid2), .out_ready(out_ready1)
`ifdef DEC_PIPE_STATS_EN
        , .stat_clr(stat_clr), .stat_beats(sb2), .stat_errs(se2)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference decode: {err, lines} for up to 8 lines, built with shifts.
    function automatic logic [8:0] mdl(input int code, input int n, input bit al, input bit rev);
        logic [7:0] l;
        logic       e;
        int         pos;
        l = 8'h00;
        e = 1'b0;
        if (code < n) begin
            pos = rev ? (n - 1 - code) : code;
            l   = 8'(1 << pos);
        end else begin
            e = 1'b1;
        end
        if (al) l = ~l & 8'((1 << n) - 1);
        return {e, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- u0 model + per-cycle compare ----------------
    logic [2:0] q[$];
    int         beats0 = 0;

    initial begin : checker_u0
        logic       exp_v, exp_rdy, in_x, out_x, prev_stall;
        logic [8:0] exp;
        logic [7:0] prev_lines;
        logic       prev_err;
        prev_stall = 1'b0;
        prev_lines = 8'h00;
        prev_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                exp_v   = (q.size() > 0);
                exp_rdy = (q.size() < 2);
                exp     = exp_v ? mdl(int'(q[0]), 8, 1'b1, 1'b1) : 9'h0FF;
                check("u0_out_valid", 32'(out_valid0), 32'(exp_v));
                check("u0_in_ready",  32'(in_ready0),  32'(exp_rdy));
                check("u0_out_lines", 32'(out_lines0), 32'(exp[7:0]));
                check("u0_out_err",   32'(out_err0),   32'(exp[8]));
                if (prev_stall) begin
                    check("u0_hold_lines", 32'(out_lines0), 32'(prev_lines));
                    check("u0_hold_err",   32'(out_err0),   32'(prev_err));
                end
                prev_stall = out_valid0 && !out_ready0;
                prev_lines = out_lines0;
                prev_err   = out_err0;
                in_x  = in_valid0 && exp_rdy;
                out_x = exp_v && out_ready0;
                if (out_x) begin
                    void'(q.pop_front());
                    beats0++;
                end
                if (in_x) q.push_back(in_code0);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin : main
        logic [7:0] sweep_exp [8];
        int         start, cyc, beats_at_rst;
        sweep_exp = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

        in_code0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        in_code1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
`ifdef DEC_PIPE_STATS_EN
        stat_clr = 1'b0;
`endif

        // Model pins (hand-computed)
        check("mdl_pin_c0",   32'(mdl(0, 8, 1'b1, 1'b1)), 32'h07F);
        check("mdl_pin_c7",   32'(mdl(7, 8, 1'b1, 1'b1)), 32'h0FE);
        check("mdl_pin_hi3",  32'(mdl(3, 8, 1'b0, 1'b0)), 32'h008);
        check("mdl_pin_n5c6", 32'(mdl(6, 5, 1'b1, 1'b1)), 32'h11F);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid0), 32'h0);
        check("rst_in_ready",  32'(in_ready0),  32'h1);
        check("rst_lines_u0",  32'(out_lines0), 32'hFF);
        check("rst_err_u0",    32'(out_err0),   32'h0);
        check("rst_lines_u1",  32'(out_lines1), 32'h00);
        check("rst_lines_u2",  32'(out_lines2), 32'h1F);
        rst_n = 1'b1;
        tick();

        // Sweep 0..7 at full rate, latency 1
        out_ready0 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid0 = 1'b1;
            in_code0  = 3'(c);
            tick();
            check("sweep_lines", 32'(out_lines0), 32'(sweep_exp[c]));
            check("sweep_valid", 32'(out_valid0), 32'h1);
            check("sweep_ready", 32'(in_ready0),  32'h1);
        end
        in_valid0 = 1'b0;
        tick();
        check("sweep_idle_valid", 32'(out_valid0), 32'h0);
        check("sweep_idle_lines", 32'(out_lines0), 32'hFF);

        // Backpressure: 2 held, 5 in skid, 6 stalled
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_code0   = 3'd2;
        tick();
        check("bp_first",    32'(out_lines0), 32'hDF);
        in_code0 = 3'd5;
        tick();
        check("bp_full_rdy", 32'(in_ready0),  32'h0);
        check("bp_held",     32'(out_lines0), 32'hDF);
        in_code0 = 3'd6;
        repeat (3) tick();
        check("bp_still",    32'(out_lines0), 32'hDF);
        check("bp_still_rdy",32'(in_ready0),  32'h0);
        out_ready0 = 1'b1;
        tick();
        check("bp_rel_5",    32'(out_lines0), 32'hFB);
        check("bp_rel_rdy",  32'(in_ready0),  32'h1);
        tick();
        check("bp_rel_6",    32'(out_lines0), 32'hFD);
        in_valid0 = 1'b0;
        tick();
        check("bp_drained",  32'(out_valid0), 32'h0);

        // Other configurations
        in_valid1 = 1'b1;
        in_code1  = 3'd3;
        tick();
        check("u1_c3_lines", 32'(out_lines1), 32'h08);
        check("u1_c3_err",   32'(out_err1),   32'h0);
        check("u2_c3_lines", 32'(out_lines2), 32'h1D);
        in_code1 = 3'd6;
        tick();
        check("u1_c6_lines", 32'(out_lines1), 32'h40);
        check("u2_c6_lines", 32'(out_lines2), 32'h1F);
        check("u2_c6_err",   32'(out_err2),   32'h1);
        check("u2_c6_valid", 32'(out_valid2), 32'h1);
        in_code1 = 3'd4;
        tick();
        check("u1_c4_lines", 32'(out_lines1), 32'h10);
        check("u2_c4_lines", 32'(out_lines2), 32'h1E);
        check("u2_c4_err",   32'(out_err2),   32'h0);
        in_valid1 = 1'b0;
        tick();
        check("u1_idle_lines", 32'(out_lines1), 32'h00);
        check("u2_idle_lines", 32'(out_lines2), 32'h1F);
        check("u2_idle_valid", 32'(out_valid2), 32'h0);
        check("u2_idle_rdy",   32'(in_ready2),  32'h1);
`ifdef DEC_PIPE_STATS_EN
        check("u2_stat_beats", 32'(sb2), 32'd3);
        check("u2_stat_errs",  32'(se2), 32'd1);
        check("u1_stat_beats", 32'(sb1), 32'd3);
        check("u1_stat_errs",  32'(se1), 32'd0);
`endif

        // Reset with two beats buffered
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_code0   = 3'd1;
        tick();
        in_code0 = 3'd4;
        tick();
        in_valid0 = 1'b0;
        check("mid_full_rdy", 32'(in_ready0), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid0), 32'h0);
        check("mid_rst_rdy",   32'(in_ready0),  32'h1);
        check("mid_rst_lines", 32'(out_lines0), 32'hFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready0 = 1'b1;
        beats_at_rst = beats0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 32'(out_valid0), 32'h0);
        end
`ifdef DEC_PIPE_STATS_EN
        check("rst_stat_beats", 32'(sb2), 32'd0);
`endif

        // Randomized traffic, 10k output beats
        start = beats0;
        cyc   = 0;
        while ((beats0 - start) < 10000 && cyc < 40000) begin
            in_valid0  = ($urandom % 4) != 0;
            in_code0   = 3'($urandom);
            out_ready0 = ($urandom % 4) != 0;
            tick();
            cyc++;
        end
        check("rand_beats_reached", 32'((beats0 - start) >= 10000), 32'h1);
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        repeat (3) tick();
        check("rand_drained", 32'(out_valid0), 32'h0);
`ifdef DEC_PIPE_STATS_EN
        check("u0_stat_beats", 32'(sb0), 32'(beats0 - beats_at_rst));
        check("u0_stat_errs",  32'(se0), 32'd0);

        // stat_clr coincident with a beat on u2
        in_valid1 = 1'b1;
        in_code1  = 3'd0;
        tick();
        in_valid1 = 1'b0;
        stat_clr  = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr_wins_beats", 32'(sb2), 32'd0);
        check("clr_wins_errs",  32'(se2), 32'd0);

        // Saturation
        in_valid1 = 1'b1;
        in_code1  = 3'd6;
        repeat (65540) tick();
        in_valid1 = 1'b0;
        tick();
        check("sat_beats", 32'(sb2), 32'hFFFF);
        check("sat_errs",  32'(se2), 32'hFFFF);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("sat_clr", 32'(sb2), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
